// File: rtl/prf_scoreboard.sv
// Multi-port physical register file with per-register ready scoreboard,
// same-cycle write bypass, optional zero register and pending counter.
module prf_scoreboard #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 64,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ALLOC_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   read_addrs,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   read_data,
  output logic [READ_PORTS-1:0]                   read_ready,
  input  logic [WRITE_PORTS-1:0]                  write_en,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  write_addrs,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  write_data,
  input  logic [ALLOC_PORTS-1:0]                  alloc_en,
  input  logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]  alloc_addrs,
  output logic [ADDR_WIDTH:0]                     num_pending
);

  localparam logic [ADDR_WIDTH:0] NREGS = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   rdy_q, rdy_d;
  logic [ADDR_WIDTH:0]   pend_q, pend_d;
  logic [READ_PORTS-1:0] hit;

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  // Register 0 (when hardwired) and out-of-range indices hold no state.
  function automatic logic wr_ok(input logic [ADDR_WIDTH-1:0] a);
    return in_rng(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  // Next state: writes in port order (highest wins), then allocations
  // override ready; pending count is taken from the next-state vector.
  always_comb begin
    regs_d = regs_q;
    rdy_d  = rdy_q;
    pend_d = '0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (write_en[j] && wr_ok(write_addrs[j])) begin
        regs_d[write_addrs[j]] = write_data[j];
        rdy_d[write_addrs[j]]  = 1'b1;
      end
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (alloc_en[a] && wr_ok(alloc_addrs[a])) begin
        rdy_d[alloc_addrs[a]] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d = pend_d + {{ADDR_WIDTH{1'b0}}, ~rdy_d[i]};
    end
  end

  // State registers; reset discards any write or allocation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rdy_q  <= '1;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      rdy_q  <= rdy_d;
      pend_q <= pend_d;
    end
  end

  // Combinational read with optional bypass of this cycle's writes.
  always_comb begin
    read_data  = '0;
    read_ready = '1;
    hit        = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      if (!rst && wr_ok(read_addrs[k])) begin
        read_data[k]  = regs_q[read_addrs[k]];
        read_ready[k] = rdy_q[read_addrs[k]];
        if (BYPASS != 0) begin
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (write_en[j] && write_addrs[j] == read_addrs[k]) begin
              read_data[k]  = write_data[j];
              read_ready[k] = 1'b1;
              hit[k]        = 1'b1;
            end
          end
          for (int a = 0; a < ALLOC_PORTS; a++) begin
            if (hit[k] && alloc_en[a] &&
                alloc_addrs[a] == read_addrs[k]) begin
              read_ready[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign num_pending = pend_q;

endmodule

// File: tb/tb_prf_scoreboard.sv
// Directed self-checking bench for prf_scoreboard: a default instance
// and a no-bypass, non-power-of-two instance sharing clock and reset.
module tb_prf_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0][5:0]  ra;
  logic [3:0][31:0] rd;
  logic [3:0]       rr;
  logic [1:0]       we;
  logic [1:0][5:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0]       ae;
  logic [1:0][5:0]  aa;
  logic [6:0]       np;

  logic [3:0][5:0]  b_ra;
  logic [3:0][31:0] b_rd;
  logic [3:0]       b_rr;
  logic [1:0]       b_we;
  logic [1:0][5:0]  b_wa;
  logic [1:0][31:0] b_wd;
  logic [1:0]       b_ae;
  logic [1:0][5:0]  b_aa;
  logic [6:0]       b_np;

  int n_chk  = 0;
  int n_fail = 0;

  prf_scoreboard dut (
    .clk(clk), .rst(rst),
    .read_addrs(ra), .read_data(rd), .read_ready(rr),
    .write_en(we), .write_addrs(wa), .write_data(wd),
    .alloc_en(ae), .alloc_addrs(aa), .num_pending(np)
  );

  prf_scoreboard #(.NUM_REGS(48), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .read_addrs(b_ra), .read_data(b_rd), .read_ready(b_rr),
    .write_en(b_we), .write_addrs(b_wa), .write_data(b_wd),
    .alloc_en(b_ae), .alloc_addrs(b_aa), .num_pending(b_np)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ra = '0; we = '0; wa = '0; wd = '0; ae = '0; aa = '0;
    b_ra = '0; b_we = '0; b_wa = '0; b_wd = '0; b_ae = '0; b_aa = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    #1;
    chk("rst_np", 32'(np), 0);
    chk("rst_np_b", 32'(b_np), 0);
    we[0] = 1'b1; wa[0] = 6'd1; wd[0] = 32'h5;
    ra[0] = 6'd1;
    #1;
    chk("rst_byp_d", rd[0], 0);
    chk("rst_byp_r", 32'(rr[0]), 1);
    clr();
    for (int g = 0; g < 16; g++) begin
      for (int p = 0; p < 4; p++) ra[p] = 6'(g * 4 + p);
      #1;
      for (int p = 0; p < 4; p++) begin
        chk("rst_rd", rd[p], 0);
        chk("rst_rr", 32'(rr[p]), 1);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    step();

    // Allocate 5, then write it back with bypass.
    ae[0] = 1'b1; aa[0] = 6'd5;
    step();
    clr();
    ra[0] = 6'd5;
    #1;
    chk("alloc5_rr", 32'(rr[0]), 0);
    chk("alloc5_np", 32'(np), 1);
    we[0] = 1'b1; wa[0] = 6'd5; wd[0] = 32'hDEADBEEF;
    #1;
    chk("wb5_byp_d", rd[0], 32'hDEADBEEF);
    chk("wb5_byp_r", 32'(rr[0]), 1);
    step();
    clr();
    ra[0] = 6'd5;
    #1;
    chk("wb5_d", rd[0], 32'hDEADBEEF);
    chk("wb5_r", 32'(rr[0]), 1);
    chk("wb5_np", 32'(np), 0);

    // Two ports write 7: port 1 wins.
    we = 2'b11; wa[0] = 6'd7; wa[1] = 6'd7;
    wd[0] = 32'h11; wd[1] = 32'h22;
    ra[1] = 6'd7;
    #1;
    chk("prio_byp", rd[1], 32'h22);
    step();
    clr();
    ra[1] = 6'd7;
    #1;
    chk("prio_st", rd[1], 32'h22);

    // Allocate and write 9 together: data lands, ready stays 0.
    ae[0] = 1'b1; aa[0] = 6'd9;
    we[0] = 1'b1; wa[0] = 6'd9; wd[0] = 32'h33;
    ra[2] = 6'd9;
    #1;
    chk("aw9_byp_d", rd[2], 32'h33);
    chk("aw9_byp_r", 32'(rr[2]), 0);
    step();
    clr();
    ra[2] = 6'd9;
    #1;
    chk("aw9_d", rd[2], 32'h33);
    chk("aw9_r", 32'(rr[2]), 0);
    chk("aw9_np", 32'(np), 1);

    // Duplicate alloc of 12 with writeback of 9 in one cycle.
    ae = 2'b11; aa[0] = 6'd12; aa[1] = 6'd12;
    we[1] = 1'b1; wa[1] = 6'd9; wd[1] = 32'h44;
    step();
    clr();
    ra[0] = 6'd9; ra[1] = 6'd12;
    #1;
    chk("dup_np", 32'(np), 1);
    chk("dup_r9", 32'(rr[0]), 1);
    chk("dup_d9", rd[0], 32'h44);
    chk("dup_r12", 32'(rr[1]), 0);

    // Register 0 ignores writes and allocations.
    we[0] = 1'b1; wa[0] = 6'd0; wd[0] = 32'hFF;
    ae[0] = 1'b1; aa[0] = 6'd0;
    ra[3] = 6'd0;
    #1;
    chk("z_byp_d", rd[3], 0);
    chk("z_byp_r", 32'(rr[3]), 1);
    step();
    clr();
    ra[3] = 6'd0;
    #1;
    chk("z_d", rd[3], 0);
    chk("z_r", 32'(rr[3]), 1);
    chk("z_np", 32'(np), 1);

    // No-bypass instance: write shows up only after the edge.
    b_we[0] = 1'b1; b_wa[0] = 6'd3; b_wd[0] = 32'h44;
    b_ra[0] = 6'd3;
    #1;
    chk("nb_old", b_rd[0], 0);
    chk("nb_old_r", 32'(b_rr[0]), 1);
    step();
    clr();
    b_ra[0] = 6'd3;
    #1;
    chk("nb_new", b_rd[0], 32'h44);

    // Out-of-range index 50 of 48 regs; 47 is the last real one.
    b_we[0] = 1'b1; b_wa[0] = 6'd50; b_wd[0] = 32'h55;
    b_ae[0] = 1'b1; b_aa[0] = 6'd60;
    b_ae[1] = 1'b1; b_aa[1] = 6'd47;
    step();
    clr();
    b_ra[0] = 6'd50; b_ra[1] = 6'd47;
    #1;
    chk("oor_d", b_rd[0], 0);
    chk("oor_r", 32'(b_rr[0]), 1);
    chk("last_r", 32'(b_rr[1]), 0);
    chk("oor_np", 32'(b_np), 1);

    // Reset in the middle of traffic.
    we[0] = 1'b1; wa[0] = 6'd20; wd[0] = 32'hAB;
    ae[1] = 1'b1; aa[1] = 6'd21;
    ra[0] = 6'd12; ra[1] = 6'd9;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_np", 32'(np), 0);
    chk("mid_np_b", 32'(b_np), 0);
    chk("mid_r12", 32'(rr[0]), 1);
    chk("mid_d9", rd[1], 0);
    step();
    rst = 1'b0;
    clr();
    step();
    ra[0] = 6'd20; ra[1] = 6'd21; ra[2] = 6'd9;
    #1;
    chk("post_d20", rd[0], 0);
    chk("post_r21", 32'(rr[1]), 1);
    chk("post_d9", rd[2], 0);
    chk("post_np", 32'(np), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
